dmux12x8_hs: RTL and testbench

- Registered 1-to-2 demultiplexer for 8-bit words; the inverse of the 2:1 byte mux used in the datapath.
- Accepts one input stream with a valid/ready handshake and steers each word to port A or port B using a per-word select.
- Each destination has its own small FIFO, so a stalled destination does not block the other.
- Sits between a shared result bus and two downstream consumers, e.g. the sum and carry paths.

---
 rtl/dmux12x8_hs_if.sv | 33 +++
 rtl/dmux12x8_hs.sv | 127 ++++++++++++
 tb/tb_dmux12x8_hs.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmux12x8_hs_if.sv
// Handshake bundle for dmux12x8_hs.
//   din/din_valid/s/din_ready : upstream word, valid, destination select, ready
//   a_*/b_*                   : per-destination data, valid, ready
//   a_count/b_count           : per-destination accepted-word counters
// slave  : the demux view
// master : the view of the environment driving and consuming it
interface dmux12x8_hs_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             s;
    logic             din_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNTW-1:0]  a_count;
    logic [CNTW-1:0]  b_count;

    modport slave (
        input  din, din_valid, s, a_ready, b_ready,
        output din_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output din, din_valid, s, a_ready, b_ready,
        input  din_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/dmux12x8_hs.sv
// dmux12x8_hs: registered 1-to-2 word demultiplexer with valid/ready.
// Each accepted word goes to destination A (s=0) or B (s=1); each
// destination owns a DEPTH-entry FIFO and a wrapping accept counter, so a
// stalled consumer only back-pressures words aimed at it.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dmux12x8_hs_if.slave (din/din_valid/s/din_ready, a_*, b_*, counts)

// One destination lane: FIFO + accept counter.
//   push        : write wdata (caller guarantees !full)
//   rdy         : consumer ready; pop = valid & rdy
//   full/valid  : occupancy flags
//   rdata       : head word, or last popped word while empty
//   count       : words pushed since reset, wrapping
module dmux12x8_hs_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rdy,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNTW-1:0]  count
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [WIDTH-1:0]             last_q;
    logic [AW-1:0]                wr_idx, rd_idx;
    logic                         empty, pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign valid  = ~empty;
    assign pop    = valid & rdy;

    // While empty the output keeps the last word handed out, not whatever
    // stale entry the read pointer happens to land on.
    assign rdata  = valid ? mem[rd_idx] : last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
            last_q <= '0;
            count  <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_idx] <= wdata;
                wr_ptr      <= wr_ptr + {{AW{1'b0}}, 1'b1};
                count       <= count + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
                last_q <= mem[rd_idx];
            end
        end
    end
endmodule

module dmux12x8_hs #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmux12x8_hs_if.slave         bus
);
    localparam int NUM_LANES = 2;

    logic                                 rst_done;
    logic                                 accept;
    logic [NUM_LANES-1:0]                 push, rdy, full, valid;
    logic [NUM_LANES-1:0][WIDTH-1:0]      rdata;
    logic [NUM_LANES-1:0][CNTW-1:0]       count;

    // Holds din_ready low through reset and until the first edge after
    // release, so nothing can be accepted while the block is coming up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // Ready depends only on the selected lane's full flag: a pop in the
    // same cycle does not open a slot for a push until the next cycle.
    assign bus.din_ready = rst_done & ~full[bus.s];
    assign accept        = bus.din_valid & bus.din_ready;
    assign push          = {accept & bus.s, accept & ~bus.s};
    assign rdy           = {bus.b_ready, bus.a_ready};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmux12x8_hs_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .wdata   (bus.din),
            .rdy     (rdy[i]),
            .full    (full[i]),
            .valid   (valid[i]),
            .rdata   (rdata[i]),
            .count   (count[i])
        );
    end

    assign bus.a_data  = rdata[0];
    assign bus.a_valid = valid[0];
    assign bus.a_count = count[0];
    assign bus.b_data  = rdata[1];
    assign bus.b_valid = valid[1];
    assign bus.b_count = count[1];
endmodule

// File: tb/tb_dmux12x8_hs.sv
// Directed bench for dmux12x8_hs. Inputs change on the falling edge,
// outputs are checked on the following falling edge (or #1 after an
// asynchronous event).
module tb_dmux12x8_hs;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    dmux12x8_hs_if #(.WIDTH(8), .CNTW(8)) bus ();

    dmux12x8_hs #(.WIDTH(8), .DEPTH(2), .CNTW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;
        tests = 0;
        fails = 0;

        // Reset with din_valid asserted: nothing may be taken in.
        reset_n       = 1'b0;
        bus.din       = 8'hAA;
        bus.din_valid = 1'b1;
        bus.s         = 1'b0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        tick();
        tick();
        chk("rst_a_valid",   {31'd0, bus.a_valid}, 32'd0);
        chk("rst_b_valid",   {31'd0, bus.b_valid}, 32'd0);
        chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
        chk("rst_a_data",    {24'd0, bus.a_data}, 32'd0);
        chk("rst_b_data",    {24'd0, bus.b_data}, 32'd0);
        chk("rst_a_count",   {24'd0, bus.a_count}, 32'd0);
        chk("rst_b_count",   {24'd0, bus.b_count}, 32'd0);

        reset_n       = 1'b1;
        bus.din_valid = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, bus.din_ready}, 32'd1);
        chk("no_accept_in_rst", {24'd0, bus.a_count}, 32'd0);

        // Single word to A, latency 1.
        bus.din = 8'h3C; bus.s = 1'b0; bus.din_valid = 1'b1; bus.a_ready = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("t1_a_valid", {31'd0, bus.a_valid}, 32'd1);
        chk("t1_a_data",  {24'd0, bus.a_data}, 32'h3C);
        chk("t1_b_valid", {31'd0, bus.b_valid}, 32'd0);
        chk("t1_a_count", {24'd0, bus.a_count}, 32'd1);
        tick();
        chk("t1_a_drained", {31'd0, bus.a_valid}, 32'd0);
        chk("t1_a_hold",    {24'd0, bus.a_data}, 32'h3C);

        // Alternating destinations, both consumers ready.
        bus.b_ready = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 8'h01; bus.s = 1'b0; tick();
        chk("t2_a_01", {24'd0, bus.a_data}, 32'h01);
        chk("t2_a_v1", {31'd0, bus.a_valid}, 32'd1);
        bus.din = 8'h02; bus.s = 1'b1; tick();
        chk("t2_b_02", {24'd0, bus.b_data}, 32'h02);
        chk("t2_b_v1", {31'd0, bus.b_valid}, 32'd1);
        chk("t2_a_v0", {31'd0, bus.a_valid}, 32'd0);
        bus.din = 8'h03; bus.s = 1'b0; tick();
        chk("t2_a_03", {24'd0, bus.a_data}, 32'h03);
        bus.din = 8'h04; bus.s = 1'b1; tick();
        chk("t2_b_04", {24'd0, bus.b_data}, 32'h04);
        bus.din_valid = 1'b0;
        tick();
        chk("t2_a_count", {24'd0, bus.a_count}, 32'd3);
        chk("t2_b_count", {24'd0, bus.b_count}, 32'd2);
        chk("t2_drained", {30'd0, bus.a_valid, bus.b_valid}, 32'd0);

        // Stall A until full; B still accepts.
        bus.a_ready = 1'b0;
        bus.din_valid = 1'b1; bus.s = 1'b0;
        bus.din = 8'h11; tick();
        bus.din = 8'h22; tick();
        #1;
        chk("t3_a_full_ready", {31'd0, bus.din_ready}, 32'd0);
        chk("t3_a_head",       {24'd0, bus.a_data}, 32'h11);
        bus.s = 1'b1; bus.din = 8'h33;
        #1;
        chk("t3_b_ready", {31'd0, bus.din_ready}, 32'd1);
        tick();
        chk("t3_b_33",     {24'd0, bus.b_data}, 32'h33);
        chk("t3_a_count",  {24'd0, bus.a_count}, 32'd5);

        // Full A with pop and push attempt in the same cycle.
        bus.s = 1'b0; bus.din = 8'h44; bus.a_ready = 1'b1;
        #1;
        chk("t4_refuse_ready", {31'd0, bus.din_ready}, 32'd0);
        tick();
        chk("t4_a_head_22",  {24'd0, bus.a_data}, 32'h22);
        chk("t4_count_held", {24'd0, bus.a_count}, 32'd5);
        chk("t4_ready_back", {31'd0, bus.din_ready}, 32'd1);
        bus.a_ready = 1'b0;
        tick();
        chk("t4_count_inc",  {24'd0, bus.a_count}, 32'd6);
        chk("t4_a_still_22", {24'd0, bus.a_data}, 32'h22);
        bus.din_valid = 1'b0; bus.a_ready = 1'b1;
        tick();
        chk("t4_a_44",  {24'd0, bus.a_data}, 32'h44);
        tick();
        chk("t4_a_empty", {31'd0, bus.a_valid}, 32'd0);

        // 256 accepts to B: in-order delivery and counter wrap (B count was 3).
        bus.s = 1'b1; bus.din_valid = 1'b1; bus.b_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            w = k[7:0] ^ 8'h5A;
            bus.din = w;
            tick();
            chk("t5_b_data",  {24'd0, bus.b_data}, {24'd0, w});
            chk("t5_b_count", {24'd0, bus.b_count}, (32'd4 + k) & 32'hFF);
        end
        bus.din_valid = 1'b0;
        tick();
        chk("t5_b_wrap", {24'd0, bus.b_count}, 32'd3);

        // Reset mid-stream with both FIFOs occupied.
        bus.a_ready = 1'b0; bus.b_ready = 1'b0; bus.din_valid = 1'b1;
        bus.s = 1'b0; bus.din = 8'h55; tick();
        bus.s = 1'b1; bus.din = 8'h66; tick();
        chk("t6_both_valid", {30'd0, bus.a_valid, bus.b_valid}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valids",  {30'd0, bus.a_valid, bus.b_valid}, 32'd0);
        chk("t6_ready",   {31'd0, bus.din_ready}, 32'd0);
        chk("t6_data",    {16'd0, bus.a_data, bus.b_data}, 32'd0);
        chk("t6_counts",  {16'd0, bus.a_count, bus.b_count}, 32'd0);
        tick();
        reset_n = 1'b1; bus.din_valid = 1'b0;
        tick();
        chk("t6_ready_up", {31'd0, bus.din_ready}, 32'd1);
        bus.s = 1'b0; bus.din = 8'h77; bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("t6_a_77",   {24'd0, bus.a_data}, 32'h77);
        chk("t6_a_v",    {31'd0, bus.a_valid}, 32'd1);
        chk("t6_a_cnt",  {24'd0, bus.a_count}, 32'd1);
        chk("t6_b_empty", {31'd0, bus.b_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
